mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the processor's instruction-fetch requester (I) and load/store requester (D).
- Sits between the arm core and a unified memory in a single-memory variant of the multicycle top.
- Holds at most one access in flight. Data has priority; a starvation counter guarantees fetch progress.
- Handles the memory's read latency and returns a registered, one-cycle-valid response to the owning requester.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- MEM_LAT, 0, cycles from the m_en cycle to m_rdata valid; legal range 0..3 (0 = asynchronous-read memory)
- STARVE_MAX, 4, consecutive data wins over a pending fetch before fetch is forced; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch response valid (one cycle)
- i_rdata  out  DW  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store
- d_addr  in  AW  data address
- d_be  in  DW/8  store byte enables
- d_wdata  in  DW  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  data response/completion (one cycle)
- d_rdata  out  DW  load data
- m_en  out  1  memory access strobe
- m_we  out  1  memory write
- m_addr  out  AW  memory address
- m_be  out  DW/8  memory byte enables
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data
- busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: may arbitrate. Goes to ACCESS on a grant.
  - ACCESS: m_en=1 for exactly one cycle. Goes to WAIT if MEM_LAT>0, else RESP.
  - WAIT: lat_cnt counts MEM_LAT-1 down to 0, then goes to RESP.
  - RESP: owner's rvalid=1. May arbitrate. Goes to ACCESS on a grant, else IDLE.
- Handshake:
  - A request transfers at a rising edge where req && gnt.
  - gnt is combinational from req and state. It is only asserted in IDLE or RESP, and never to both requesters.
  - At transfer, the arbiter latches addr, we, be and wdata. The requester may change or drop req the next cycle.
  - A requester holds req and its payload stable until gnt.
- Arbitration, when both requesters are high:
  - D wins unless starve_cnt == STARVE_MAX; then I wins.
  - starve_cnt increments on each D grant while i_req=1. It clears on any I grant.
  - A single requester always wins.
- Timing:
  - Grant in cycle T. m_en, m_we, m_addr, m_be, m_wdata driven from registers in T+1.
  - m_rdata is sampled at the end of cycle T+1+MEM_LAT.
  - rvalid and rdata are registered and valid in cycle T+2+MEM_LAT.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles, because a grant in RESP issues the next ACCESS immediately.
- Stores:
  - m_we=1 only in the ACCESS cycle.
  - d_rvalid still pulses as completion, with d_rdata=0.
- Outputs outside ACCESS: m_en=0 and m_we=0. m_addr, m_be and m_wdata hold their last values.
- rdata holds its value after rvalid until the next response from the same requester.
- Reset (asynchronous, active-low, any state, including mid-access):
  - State returns to IDLE. starve_cnt and lat_cnt are cleared.
  - All outputs go to 0, and registered data/address outputs are cleared to 0.
  - An in-flight access is abandoned and no rvalid is produced.
  - A requester that was granted must re-request.
- The first arbitration after reset release occurs in the first cycle with reset high.

Optional Feature:
- Macro ARB_PERF_CNT_EN adds three 32-bit output ports:
  - i_grant_cnt: fetch grants
  - d_grant_cnt: data grants
  - i_stall_cnt: cycles with i_req=1 and i_gnt=0
- All three are saturating at 2^32-1 and reset to 0.
- Without the macro, these ports and their registers are absent and the rest of the behaviour is identical.

Test Plan:
- MEM_LAT=0, single load:
  - Stimulus: d_req=1, d_addr=0x40 in cycle 0; memory returns 0xDEADBEEF.
  - Required: d_gnt=1 in cycle 0; m_en=1 and m_addr=0x40 in cycle 1; d_rvalid=1 and d_rdata=0xDEADBEEF in cycle 2; busy=0 in cycle 3.
- MEM_LAT=2, store:
  - Stimulus: d_we=1, d_be=4'b0010, d_wdata=0x0000AB00, d_addr=0x84.
  - Required: m_we=1 with those values only in cycle 1; d_rvalid in cycle 4 with d_rdata=0; i_rvalid stays 0.
- Contention, STARVE_MAX=4:
  - Stimulus: i_req and d_req held high continuously.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; grants spaced MEM_LAT+2 cycles apart.
- Back-to-back fetch:
  - Stimulus: i_req re-asserted in each RESP cycle.
  - Required: i_gnt in RESP; the next m_en comes in the following cycle, with no IDLE cycle between.
- Reset mid-access:
  - Stimulus: reset asserted low during WAIT with MEM_LAT=3.
  - Required: busy, m_en, i_rvalid and d_rvalid go to 0 immediately; no rvalid ever appears for the abandoned access; a new request after release completes normally.
- With ARB_PERF_CNT_EN:
  - Stimulus: the contention scenario run for 10 grants.
  - Required: d_grant_cnt=8, i_grant_cnt=2, and i_stall_cnt equal to the counted stall cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (I) and load/store (D).
// Define ARB_PERF_CNT_EN to add the saturating grant/stall performance counters.
module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_be,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW/8-1:0] m_be,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     i_grant_cnt,
  output logic [31:0]     d_grant_cnt,
  output logic [31:0]     i_stall_cnt
`endif
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned LW = 2;
  localparam int unsigned SW = 4;
  localparam logic [LW-1:0] LAT_INIT = (MEM_LAT > 0) ? LW'(MEM_LAT - 1) : '0;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q;
  logic          owner_d_q;
  logic          op_we_q;
  logic          gnt_any_c;
  logic          capture_c;
  req_t          sel_c;

  // Next state and combinational grants; grants only in IDLE/RESP and never while in reset.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (reset) begin
          if (i_req && (!d_req || (starve_q == STARVE_LIM))) begin
            i_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end
        end
        state_d = (i_gnt || d_gnt) ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        if (MEM_LAT == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          lat_d   = LAT_INIT;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt_any_c = i_gnt || d_gnt;

  // m_rdata is valid on the last cycle before RESP.
  assign capture_c = ((state_q == S_ACCESS) && (MEM_LAT == 0)) ||
                     ((state_q == S_WAIT) && (lat_q == '0));

  // Payload of the winning requester; fetches read the whole word.
  always_comb begin
    sel_c = '0;
    if (i_gnt) begin
      sel_c.we    = 1'b0;
      sel_c.addr  = i_addr;
      sel_c.be    = '1;
      sel_c.wdata = '0;
    end else begin
      sel_c.we    = d_we;
      sel_c.addr  = d_addr;
      sel_c.be    = d_be;
      sel_c.wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      starve_q  <= '0;
      owner_d_q <= 1'b0;
      op_we_q   <= 1'b0;
      busy      <= 1'b0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_be      <= '0;
      m_wdata   <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      busy     <= (state_d != S_IDLE);
      m_en     <= gnt_any_c;
      m_we     <= d_gnt && d_we;
      i_rvalid <= capture_c && !owner_d_q;
      d_rvalid <= capture_c && owner_d_q;

      if (gnt_any_c) begin
        m_addr    <= sel_c.addr;
        m_be      <= sel_c.be;
        m_wdata   <= sel_c.wdata;
        op_we_q   <= sel_c.we;
        owner_d_q <= d_gnt;
      end

      // Fetch progress: count data wins that bypassed a waiting fetch.
      if (i_gnt) begin
        starve_q <= '0;
      end else if (d_gnt && i_req && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + SW'(1);
      end

      if (capture_c && !owner_d_q) begin
        i_rdata <= m_rdata;
      end
      if (capture_c && owner_d_q) begin
        d_rdata <= op_we_q ? '0 : m_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      i_stall_cnt <= '0;
    end else begin
      if (i_gnt && (i_grant_cnt != '1)) begin
        i_grant_cnt <= i_grant_cnt + 32'd1;
      end
      if (d_gnt && (d_grant_cnt != '1)) begin
        d_grant_cnt <= d_grant_cnt + 32'd1;
      end
      if (i_req && !i_gnt && (i_stall_cnt != '1)) begin
        i_stall_cnt <= i_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 0, 2, 3) checked against a cycle-indexed
// transaction model, plus directed scenarios with hand-computed values.
module tb_mem_arbiter;

  localparam int NI   = 3;
  localparam int SMAX = 4;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic int stage_of(input int k);
    return (lat_of(k) == 0) ? 0 : lat_of(k) - 1;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  logic        clk;
  logic        reset;
  logic        i_req    [NI];
  logic [31:0] i_addr   [NI];
  logic        i_gnt    [NI];
  logic        i_rvalid [NI];
  logic [31:0] i_rdata  [NI];
  logic        d_req    [NI];
  logic        d_we     [NI];
  logic [31:0] d_addr   [NI];
  logic [3:0]  d_be     [NI];
  logic [31:0] d_wdata  [NI];
  logic        d_gnt    [NI];
  logic        d_rvalid [NI];
  logic [31:0] d_rdata  [NI];
  logic        m_en     [NI];
  logic        m_we     [NI];
  logic [31:0] m_addr   [NI];
  logic [3:0]  m_be     [NI];
  logic [31:0] m_wdata  [NI];
  logic [31:0] m_rdata  [NI];
  logic        busy     [NI];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_grant_cnt [NI];
  logic [31:0] d_grant_cnt [NI];
  logic [31:0] i_stall_cnt [NI];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(lat_of(g)), .STARVE_MAX(SMAX)
    ) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(i_gnt[g]),
      .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_be(d_be[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_be(m_be[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g]), .busy(busy[g])
`ifdef ARB_PERF_CNT_EN
      , .i_grant_cnt(i_grant_cnt[g]), .d_grant_cnt(d_grant_cnt[g]), .i_stall_cnt(i_stall_cnt[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got 0x%08h expected 0x%08h", name, k, cyc, act, exp);
    end
  endtask

  task automatic chkb(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, k, cyc, act, exp);
    end
  endtask

  // Memory environment: writes at the access edge, read data only valid MEM_LAT cycles after m_en.
  logic [31:0] env_mem [NI][64];
  logic        en_d    [NI][3];
  logic [5:0]  addr_d  [NI][3];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!reset) begin
        for (int i = 0; i < 64; i++) env_mem[k][i] <= init_word(i);
        for (int s = 0; s < 3; s++) begin
          en_d[k][s]   <= 1'b0;
          addr_d[k][s] <= '0;
        end
      end else begin
        if (m_en[k] && m_we[k])
          for (int b = 0; b < 4; b++)
            if (m_be[k][b]) env_mem[k][m_addr[k][7:2]][8*b +: 8] <= m_wdata[k][8*b +: 8];
        en_d[k][0]   <= m_en[k];
        addr_d[k][0] <= m_addr[k][7:2];
        for (int s = 1; s < 3; s++) begin
          en_d[k][s]   <= en_d[k][s-1];
          addr_d[k][s] <= addr_d[k][s-1];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      m_rdata[k] = 32'hBAD0_0000 | 32'(k);
      if (lat_of(k) == 0) begin
        if (m_en[k]) m_rdata[k] = env_mem[k][m_addr[k][7:2]];
      end else if (en_d[k][stage_of(k)]) begin
        m_rdata[k] = env_mem[k][addr_d[k][stage_of(k)]];
      end
    end
  end

  // Transaction model: a grant at cycle T occupies T+1..T+2+L and answers at T+2+L.
  int          last_g  [NI];
  int          free_at [NI];
  int          resp_at [NI];
  int          starve  [NI];
  int          stall_n [NI];
  bit          rp      [NI];
  bit          g_d     [NI];
  bit          g_we    [NI];
  logic [31:0] g_addr  [NI];
  logic [31:0] g_wdata [NI];
  logic [3:0]  g_be    [NI];
  logic [31:0] ei      [NI];
  logic [31:0] ed      [NI];
  logic [31:0] mm      [NI][64];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit em, ebusy, eiv, edv, eig, edg;
      int L;
      L = lat_of(k);
      if (!reset) begin
        last_g[k] = -1000; free_at[k] = 0; resp_at[k] = 0; starve[k] = 0; stall_n[k] = 0;
        rp[k] = 0; g_d[k] = 0; g_we[k] = 0; g_addr[k] = '0; g_wdata[k] = '0; g_be[k] = '0;
        ei[k] = '0; ed[k] = '0;
        for (int i = 0; i < 64; i++) mm[k][i] = init_word(i);
        eig = 0; edg = 0; em = 0; ebusy = 0; eiv = 0; edv = 0;
      end else begin
        em    = (cyc == last_g[k] + 1);
        ebusy = (cyc > last_g[k]) && (cyc <= last_g[k] + 2 + L);
        if (em && g_we[k])
          for (int b = 0; b < 4; b++)
            if (g_be[k][b]) mm[k][g_addr[k][7:2]][8*b +: 8] = g_wdata[k][8*b +: 8];
        eiv = 0; edv = 0;
        if (rp[k] && (cyc == resp_at[k])) begin
          rp[k] = 0;
          if (g_d[k]) begin
            edv = 1;
            ed[k] = g_we[k] ? 32'h0 : mm[k][g_addr[k][7:2]];
          end else begin
            eiv = 1;
            ei[k] = mm[k][g_addr[k][7:2]];
          end
        end
        eig = 0; edg = 0;
        if (cyc >= free_at[k]) begin
          if (i_req[k] && (!d_req[k] || starve[k] == SMAX)) eig = 1;
          else if (d_req[k]) edg = 1;
        end
      end
      chkb("i_gnt", k, i_gnt[k], eig);
      chkb("d_gnt", k, d_gnt[k], edg);
      chkb("busy", k, busy[k], ebusy);
      chkb("m_en", k, m_en[k], em);
      chkb("m_we", k, m_we[k], em && g_we[k]);
      chk("m_addr", k, m_addr[k], g_addr[k]);
      chk("m_be", k, 32'(m_be[k]), 32'(g_be[k]));
      chk("m_wdata", k, m_wdata[k], g_wdata[k]);
      chkb("i_rvalid", k, i_rvalid[k], eiv);
      chkb("d_rvalid", k, d_rvalid[k], edv);
      chk("i_rdata", k, i_rdata[k], ei[k]);
      chk("d_rdata", k, d_rdata[k], ed[k]);
      if (reset && i_req[k] && !eig) stall_n[k]++;
      if (eig || edg) begin
        if (edg && i_req[k]) starve[k]++;
        if (eig) starve[k] = 0;
        g_d[k]     = edg;
        g_we[k]    = edg && d_we[k];
        g_addr[k]  = eig ? i_addr[k] : d_addr[k];
        g_be[k]    = eig ? 4'hF : d_be[k];
        g_wdata[k] = eig ? 32'h0 : d_wdata[k];
        last_g[k]  = cyc;
        free_at[k] = cyc + 2 + L;
        resp_at[k] = cyc + 2 + L;
        rp[k]      = 1;
      end
    end
  end

  initial begin
    string seq;
    int    n;
    int    gc [10];

    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      i_req[k] = 0; i_addr[k] = '0; d_req[k] = 0; d_we[k] = 0;
      d_addr[k] = '0; d_be[k] = 4'hF; d_wdata[k] = '0;
    end
    @(negedge clk);
    chkb("rst_busy", 0, busy[0], 1'b0);
    chk("rst_m_addr", 0, m_addr[0], 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // MEM_LAT=0 load: arbitrates in the first cycle after reset release.
    d_req[0] = 1; d_addr[0] = 32'h40;
    @(negedge clk); chkb("t1_gnt", 0, d_gnt[0], 1'b1);
    @(posedge clk); #1 d_req[0] = 0;
    @(negedge clk); chkb("t1_m_en", 0, m_en[0], 1'b1); chk("t1_m_addr", 0, m_addr[0], 32'h40);
    @(negedge clk); chkb("t1_rvalid", 0, d_rvalid[0], 1'b1); chk("t1_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);
    @(negedge clk); chkb("t1_busy", 0, busy[0], 1'b0);

    // MEM_LAT=0 back-to-back fetch: grant in RESP, next m_en immediately after.
    @(posedge clk); #1 i_req[0] = 1; i_addr[0] = 32'h10;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chkb("b2b_gnt", 0, i_gnt[0], (j % 2) == 0);
      chkb("b2b_m_en", 0, m_en[0], (j % 2) == 1);
      if (j > 0) chkb("b2b_busy", 0, busy[0], 1'b1);
      if (j == 2) chk("b2b_rdata", 0, i_rdata[0], 32'hC0DE_0004);
      if (j == 3) chk("b2b_m_addr", 0, m_addr[0], 32'h14);
      @(posedge clk); #1;
      if ((j % 2) == 0) i_addr[0] = i_addr[0] + 32'd4;
    end
    i_req[0] = 0;

    // MEM_LAT=2 store, then read back the merged word.
    @(posedge clk); #1;
    d_req[1] = 1; d_we[1] = 1; d_be[1] = 4'b0010; d_wdata[1] = 32'h0000_AB00; d_addr[1] = 32'h84;
    @(negedge clk); chkb("st_gnt", 1, d_gnt[1], 1'b1);
    @(posedge clk); #1 d_req[1] = 0; d_we[1] = 0; d_be[1] = 4'hF;
    @(negedge clk);
    chkb("st_m_we", 1, m_we[1], 1'b1); chk("st_m_be", 1, 32'(m_be[1]), 32'h2);
    chk("st_m_wdata", 1, m_wdata[1], 32'h0000_AB00); chk("st_m_addr", 1, m_addr[1], 32'h84);
    for (int j = 2; j <= 4; j++) begin
      @(negedge clk);
      chkb("st_m_we_off", 1, m_we[1], 1'b0);
      chkb("st_i_rvalid", 1, i_rvalid[1], 1'b0);
      chkb("st_d_rvalid", 1, d_rvalid[1], j == 4);
      if (j == 4) chk("st_d_rdata", 1, d_rdata[1], 32'h0);
    end
    @(posedge clk); #1 d_req[1] = 1; d_addr[1] = 32'h84;
    @(negedge clk); chkb("ld_gnt", 1, d_gnt[1], 1'b1);
    @(posedge clk); #1 d_req[1] = 0;
    repeat (4) @(negedge clk);
    chkb("ld_rvalid", 1, d_rvalid[1], 1'b1); chk("ld_rdata", 1, d_rdata[1], 32'hC0DE_AB21);

    // MEM_LAT=3 load abandoned by reset during WAIT.
    @(posedge clk); #1 d_req[2] = 1; d_addr[2] = 32'h44;
    @(negedge clk); chkb("rm_gnt", 2, d_gnt[2], 1'b1);
    @(posedge clk); #1 d_req[2] = 0;
    @(negedge clk);
    @(negedge clk); chkb("rm_busy_wait", 2, busy[2], 1'b1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chkb("rm_busy", 2, busy[2], 1'b0); chkb("rm_m_en", 2, m_en[2], 1'b0);
    chkb("rm_i_rvalid", 2, i_rvalid[2], 1'b0); chkb("rm_d_rvalid", 2, d_rvalid[2], 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (8) begin
      @(negedge clk); chkb("rm_no_rvalid", 2, d_rvalid[2], 1'b0);
    end
    @(posedge clk); #1 d_req[2] = 1; d_addr[2] = 32'h48;
    @(negedge clk); chkb("rm2_gnt", 2, d_gnt[2], 1'b1);
    @(posedge clk); #1 d_req[2] = 0;
    repeat (5) @(negedge clk);
    chkb("rm2_rvalid", 2, d_rvalid[2], 1'b1); chk("rm2_rdata", 2, d_rdata[2], 32'hC0DE_0012);

    // MEM_LAT=2 contention with both requests held high.
    @(posedge clk); #1;
    i_req[1] = 1; i_addr[1] = 32'h100; d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h40;
    seq = ""; n = 0;
    for (int t = 0; t < 200 && n < 10; t++) begin
      @(negedge clk);
      if (d_gnt[1]) begin seq = {seq, "D"}; gc[n] = cyc; n++; end
      else if (i_gnt[1]) begin seq = {seq, "I"}; gc[n] = cyc; n++; end
      if (n < 10) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 i_req[1] = 0; d_req[1] = 0;
    checks++;
    if (n != 10 || seq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL contention_order: got %s (%0d grants) expected DDDDIDDDDI", seq, n);
    end
    for (int j = 1; j < n; j++) chk("contention_spacing", 1, 32'(gc[j] - gc[j-1]), 32'd4);
`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    chk("perf_d_grant", 1, d_grant_cnt[1], 32'd8);
    chk("perf_i_grant", 1, i_grant_cnt[1], 32'd2);
    chk("perf_i_stall", 1, i_stall_cnt[1], 32'(stall_n[1]));
    chk("perf_i_stall_lit", 1, i_stall_cnt[1], 32'd35);
`endif

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
